ysyx_22050612_decode_stage: RTL and testbench

Registered, handshaked RISC-V instruction decode stage, parametrised in XLEN. It sits between the fetch stage and execute. It accepts {pc, inst} via valid/ready and emits one registered decode bundle: register indices, a single format-selected sign-extended immediate, an operation ID, and illegal/ebreak flags. An ebreak that is handed downstream moves the stage into a HALT state that blocks further decode until reset.

---
 rtl/ysyx_22050612_decode_stage.sv | 219 +++++++++++++++++++++
 tb/tb_ysyx_22050612_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_decode_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_decode_stage
//   Registered, valid/ready handshaked RISC-V decode stage between fetch and
//   execute. Each accepted {pc, inst} becomes one registered bundle: register
//   indices, a format-selected sign-extended immediate, an operation ID and
//   illegal/ebreak flags. When an ebreak bundle is handed to execute, the
//   stage enters HALT and accepts nothing more until reset.
//
// Parameters
//   XLEN : width of pc and immediate (32 or 64)
//   OPW  : width of the operation ID
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   in_valid/ready   : fetch handshake (in_ready is combinational)
//   in_pc, in_inst   : offered PC and instruction word
//   flush            : drop the held bundle, block loading this cycle
//   out_valid/ready  : execute handshake
//   out_pc, out_rd, out_rs1, out_rs2, out_imm, out_op,
//   out_illegal, out_ebreak : registered decode bundle
//   halted           : stage is in HALT
// ---------------------------------------------------------------------------
module ysyx_22050612_decode_stage #(
  parameter int XLEN = 64,
  parameter int OPW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [OPW-1:0]  out_op,
  output logic            out_illegal,
  output logic            out_ebreak,
  output logic            halted
);

  localparam logic [OPW-1:0] OP_NONE   = OPW'(0);
  localparam logic [OPW-1:0] OP_LUI    = OPW'(1);
  localparam logic [OPW-1:0] OP_AUIPC  = OPW'(2);
  localparam logic [OPW-1:0] OP_JAL    = OPW'(3);
  localparam logic [OPW-1:0] OP_JALR   = OPW'(4);
  localparam logic [OPW-1:0] OP_SUB    = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE    = OPW'(6);
  localparam logic [OPW-1:0] OP_BEQ    = OPW'(7);
  localparam logic [OPW-1:0] OP_ADD    = OPW'(8);
  localparam logic [OPW-1:0] OP_SD     = OPW'(9);
  localparam logic [OPW-1:0] OP_LD     = OPW'(10);
  localparam logic [OPW-1:0] OP_LW     = OPW'(13);
  localparam logic [OPW-1:0] OP_ADDI   = OPW'(19);
  localparam logic [OPW-1:0] OP_SLTIU  = OPW'(21);
  localparam logic [OPW-1:0] OP_EBREAK = OPW'(22);

  // ld/sd only exist in the 64-bit base ISA.
  localparam logic RV64 = (XLEN == 64);

  typedef enum logic [2:0] {
    FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  // All immediates are first formed as 32-bit sign-extended values; widening
  // to XLEN replicates bit 31 (a no-op when XLEN is 32).
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] v_s;
    v_s = v;
    return XLEN'(v_s);
  endfunction

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_pc;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [XLEN-1:0]   r_imm;
  logic [OPW-1:0]    r_op;
  logic              r_illegal;
  logic              r_ebreak;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [OPW-1:0]    w_op;
  fmt_e              w_fmt;
  logic [31:0]       w_imm32;
  logic [XLEN-1:0]   w_imm;
  logic              w_drain;
  logic              w_halt_go;
  logic              w_load;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];

  // Operation ID and immediate format; an unmatched encoding leaves op=0,
  // which doubles as the illegal indication.
  always_comb begin
    w_op  = OP_NONE;
    w_fmt = FMT_NONE;
    case (w_opcode)
      7'b0110111: begin w_op = OP_LUI;   w_fmt = FMT_U; end
      7'b0010111: begin w_op = OP_AUIPC; w_fmt = FMT_U; end
      7'b1101111: begin w_op = OP_JAL;   w_fmt = FMT_J; end
      7'b1100111: begin
        if (w_f3 == 3'b000) begin w_op = OP_JALR; w_fmt = FMT_I; end
      end
      7'b0110011: begin
        if (w_f3 == 3'b000 && w_f7 == 7'b0000000) w_op = OP_ADD;
        else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) w_op = OP_SUB;
      end
      7'b1100011: begin
        if (w_f3 == 3'b000) begin w_op = OP_BEQ; w_fmt = FMT_B; end
        else if (w_f3 == 3'b001) begin w_op = OP_BNE; w_fmt = FMT_B; end
      end
      7'b0100011: begin
        if (RV64 && w_f3 == 3'b011) begin w_op = OP_SD; w_fmt = FMT_S; end
      end
      7'b0000011: begin
        if (RV64 && w_f3 == 3'b011) begin w_op = OP_LD; w_fmt = FMT_I; end
        else if (w_f3 == 3'b010) begin w_op = OP_LW; w_fmt = FMT_I; end
      end
      7'b0010011: begin
        if (w_f3 == 3'b000) begin w_op = OP_ADDI; w_fmt = FMT_I; end
        else if (w_f3 == 3'b011) begin w_op = OP_SLTIU; w_fmt = FMT_I; end
      end
      7'b1110011: begin
        // ebreak is an I-type encoding, so its immediate field (1) is reported.
        if (in_inst == 32'h0010_0073) begin w_op = OP_EBREAK; w_fmt = FMT_I; end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_imm32 = 32'd0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S: w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B: w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                        in_inst[30:25], in_inst[11:8], 1'b0};
      FMT_U: w_imm32 = {in_inst[31:12], 12'd0};
      FMT_J: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                        in_inst[20], in_inst[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
  end

  assign w_imm = sext32(w_imm32);

  // Handshake control. A draining ebreak halts the stage; anything fetch
  // offers in that same cycle is not loaded, since the stage is stopping.
  assign in_ready  = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_drain   = r_out_valid && out_ready;
  assign w_halt_go = (r_state == S_RUN) && w_drain && r_ebreak;
  assign w_load    = in_valid && in_ready && !flush && !w_halt_go;

  always_comb begin
    w_state_nxt = r_state;
    if (w_halt_go) w_state_nxt = S_HALT;
  end

  // Stage boundary: decode bundle register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_op        <= '0;
      r_illegal   <= 1'b0;
      r_ebreak    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_pc        <= in_pc;
        r_rd        <= in_inst[11:7];
        r_rs1       <= in_inst[19:15];
        r_rs2       <= in_inst[24:20];
        r_imm       <= w_imm;
        r_op        <= w_op;
        r_illegal   <= (w_op == OP_NONE);
        r_ebreak    <= (w_op == OP_EBREAK);
      end else if (flush || w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_pc;
  assign out_rd      = r_rd;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_imm     = r_imm;
  assign out_op      = r_op;
  assign out_illegal = r_illegal;
  assign out_ebreak  = r_ebreak;
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_ysyx_22050612_decode_stage.sv
// ---------------------------------------------------------------------------
// Bench for ysyx_22050612_decode_stage. A 64-bit and a 32-bit instance share
// the same stimulus. A transaction-level reference (template table decode plus
// a small valid/halt model) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ysyx_22050612_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;

  logic        in_ready, out_valid, out_illegal, out_ebreak, halted;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [7:0]  out_op;

  logic        in_ready32, out_valid32, ill32, ebk32, halted32;
  logic [31:0] out_pc32, imm32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [7:0]  op32;

  always #5 clk = ~clk;

  ysyx_22050612_decode_stage #(.XLEN(64), .OPW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_op(out_op), .out_illegal(out_illegal),
    .out_ebreak(out_ebreak), .halted(halted)
  );

  ysyx_22050612_decode_stage #(.XLEN(32), .OPW(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_pc(in_pc[31:0]), .in_inst(in_inst), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
    .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_imm(imm32), .out_op(op32), .out_illegal(ill32),
    .out_ebreak(ebk32), .halted(halted32)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          op;
    int          fmt;      // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
    bit          rv64only;
  } tmpl_t;

  tmpl_t tbl[14];

  // Reference model state
  bit          m_valid, m_halt;
  logic [63:0] m_pc, m_imm;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [7:0]  m_op, m_op32;
  logic        m_ill, m_ebk, m_ill32;
  logic [31:0] m_imm32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_t(input int i, input logic [31:0] mk, input logic [31:0] mt,
                       input int op, input int fmt, input bit r64);
    tbl[i].mask = mk; tbl[i].match = mt; tbl[i].op = op;
    tbl[i].fmt = fmt; tbl[i].rv64only = r64;
  endtask

  task automatic init_tbl();
    set_t(0,  32'h0000_007F, 32'h0000_0037, 1,  4, 0); // lui
    set_t(1,  32'h0000_007F, 32'h0000_0017, 2,  4, 0); // auipc
    set_t(2,  32'h0000_007F, 32'h0000_006F, 3,  5, 0); // jal
    set_t(3,  32'h0000_707F, 32'h0000_0067, 4,  1, 0); // jalr
    set_t(4,  32'hFE00_707F, 32'h4000_0033, 5,  0, 0); // sub
    set_t(5,  32'h0000_707F, 32'h0000_1063, 6,  3, 0); // bne
    set_t(6,  32'h0000_707F, 32'h0000_0063, 7,  3, 0); // beq
    set_t(7,  32'hFE00_707F, 32'h0000_0033, 8,  0, 0); // add
    set_t(8,  32'h0000_707F, 32'h0000_3023, 9,  2, 1); // sd
    set_t(9,  32'h0000_707F, 32'h0000_3003, 10, 1, 1); // ld
    set_t(10, 32'h0000_707F, 32'h0000_2003, 13, 1, 0); // lw
    set_t(11, 32'h0000_707F, 32'h0000_0013, 19, 1, 0); // addi
    set_t(12, 32'h0000_707F, 32'h0000_3013, 21, 1, 0); // sltiu
    set_t(13, 32'hFFFF_FFFF, 32'h0010_0073, 22, 1, 0); // ebreak
  endtask

  function automatic void ref_dec(input logic [31:0] w, input bit rv64,
                                  output logic [7:0] op, output logic [63:0] imm,
                                  output logic ill, output logic ebk);
    int fmt = 0;
    longint v = 0;
    op = 8'd0;
    for (int i = 0; i < 14; i++) begin
      if (op == 8'd0 && (w & tbl[i].mask) == tbl[i].match && (rv64 || !tbl[i].rv64only)) begin
        op  = 8'(tbl[i].op);
        fmt = tbl[i].fmt;
      end
    end
    case (fmt)
      1: v = $signed(w[31:20]);
      2: v = $signed({w[31:25], w[11:7]});
      3: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      4: v = $signed({w[31:12], 12'd0});
      5: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: v = 0;
    endcase
    imm = rv64 ? 64'(v) : {32'd0, v[31:0]};
    ill = (op == 8'd0);
    ebk = (op == 8'd22);
  endfunction

  // One clock: check in_ready before the edge, advance the model with the
  // inputs presented this cycle, then compare every output after the edge.
  task automatic tick();
    bit rdy, drain;
    logic [63:0] imm64_n, imm32_n;
    #1;
    rdy = !m_halt && (!m_valid || out_ready);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("in_ready32", 64'(in_ready32), 64'(rdy));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_halt = 0; m_pc = 0; m_imm = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      m_op = 0; m_ill = 0; m_ebk = 0; m_op32 = 0; m_ill32 = 0; m_imm32 = 0;
    end else begin
      drain = m_valid && out_ready;
      if (!m_halt && drain && m_ebk) begin
        m_halt = 1; m_valid = 0;
      end else if (flush) begin
        m_valid = 0;
      end else if (in_valid && rdy) begin
        m_valid = 1;
        m_pc = in_pc;
        m_rd = in_inst[11:7]; m_rs1 = in_inst[19:15]; m_rs2 = in_inst[24:20];
        ref_dec(in_inst, 1'b1, m_op, imm64_n, m_ill, m_ebk);
        m_imm = imm64_n;
        begin
          logic e32;
          ref_dec(in_inst, 1'b0, m_op32, imm32_n, m_ill32, e32);
          m_imm32 = imm32_n[31:0];
        end
      end else if (drain) begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("halted", 64'(halted), 64'(m_halt));
    chk("out_pc", out_pc, m_pc);
    chk("regs", 64'({out_rd, out_rs1, out_rs2}), 64'({m_rd, m_rs1, m_rs2}));
    chk("out_op", 64'(out_op), 64'(m_op));
    chk("out_imm", out_imm, m_imm);
    chk("out_illegal", 64'(out_illegal), 64'(m_ill));
    chk("out_ebreak", 64'(out_ebreak), 64'(m_ebk));
    chk("valid32", 64'(out_valid32), 64'(m_valid));
    chk("halted32", 64'(halted32), 64'(m_halt));
    chk("pc32", 64'(out_pc32), 64'(m_pc[31:0]));
    chk("regs32", 64'({rd32, rs1_32, rs2_32}), 64'({m_rd, m_rs1, m_rs2}));
    chk("op32", 64'(op32), 64'(m_op32));
    chk("imm32", 64'(imm32), 64'(m_imm32));
    chk("ill32", 64'(ill32), 64'(m_ill32));
    chk("ebk32", 64'(ebk32), 64'(m_ebk));
  endtask

  logic [31:0] stream[4];
  logic [4:0]  got[$];
  int          idx;

  initial begin
    init_tbl();
    m_valid = 0; m_halt = 0; m_pc = 0; m_imm = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    m_op = 0; m_ill = 0; m_ebk = 0; m_op32 = 0; m_ill32 = 0; m_imm32 = 0;
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; in_pc = 0; in_inst = 0;
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    rst = 0;

    // addi x1,x0,5
    in_valid = 1; in_inst = 32'h0050_0093; in_pc = 64'h1000; out_ready = 1;
    tick();
    in_valid = 0;
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_op", 64'(out_op), 64'd19);
    chk("addi_rd", 64'(out_rd), 64'd1);
    chk("addi_rs1", 64'(out_rs1), 64'd0);
    chk("addi_imm", out_imm, 64'd5);
    chk("addi_ill", 64'(out_illegal), 64'd0);
    tick();

    // bne x1,x2,-4 then lui x5,0x80000
    in_valid = 1; in_inst = 32'hFE20_9EE3; in_pc = 64'h2000;
    tick();
    chk("bne_op", 64'(out_op), 64'd6);
    chk("bne_rs", 64'({out_rs1, out_rs2}), 64'({5'd1, 5'd2}));
    chk("bne_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    in_inst = 32'h8000_02B7; in_pc = 64'h2004;
    tick();
    in_valid = 0;
    chk("lui_op", 64'(out_op), 64'd1);
    chk("lui_rd", 64'(out_rd), 64'd5);
    chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", 64'(imm32), 64'h8000_0000);
    tick();

    // Stream of 4 with a 3-cycle execute stall mid-stream
    stream[0] = 32'h0010_0093; stream[1] = 32'h0020_0113;
    stream[2] = 32'h0030_0193; stream[3] = 32'h0040_0213;
    idx = 0;
    got.delete();
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (idx < 4);
      in_inst   = (idx < 4) ? stream[idx] : 32'h0;
      in_pc     = 64'h3000 + 64'(4 * idx);
      #1;
      if (c >= 3 && c <= 4) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) got.push_back(out_rd);
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 0;
    chk("stream_count", 64'(got.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) chk("stream_order", 64'(got[k]), 64'(k + 1));

    // ebreak drained -> HALT, then reset
    out_ready = 1; in_valid = 1; in_inst = 32'h0010_0073; in_pc = 64'h4000;
    tick();
    in_inst = 32'h0050_0093;
    tick();
    chk("halt_set", 64'(halted), 64'd1);
    chk("halt_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("halt_ignore", 64'(out_valid), 64'd0);
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("halt_rst", 64'(halted), 64'd0);
    chk("halt_rst_valid", 64'(out_valid), 64'd0);

    // ebreak held then flushed: no halt, next addi accepted
    out_ready = 0; in_valid = 1; in_inst = 32'h0010_0073;
    tick();
    in_valid = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_halt", 64'(halted), 64'd0);
    in_valid = 1; in_inst = 32'h0050_0093; out_ready = 1;
    tick();
    in_valid = 0;
    chk("flush_next_op", 64'(out_op), 64'd19);
    tick();

    // illegal word, then ld (illegal only at XLEN=32), then reset with valid held
    in_valid = 1; in_inst = 32'hFFFF_FFFF;
    tick();
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_op", 64'(out_op), 64'd0);
    chk("ill_imm", out_imm, 64'd0);
    in_inst = 32'h0000_B183;
    tick();
    in_valid = 0; out_ready = 0;
    chk("ld_op", 64'(out_op), 64'd10);
    chk("ld32_ill", 64'(ill32), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_drop", 64'(out_valid), 64'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int k;
      logic [31:0] r;
      k = $urandom_range(0, 19);
      r = $urandom;
      if (k < 13)       in_inst = (r & ~tbl[k].mask) | tbl[k].match;
      else if (k == 13) in_inst = ($urandom_range(0, 39) == 0) ? 32'h0010_0073 : r;
      else              in_inst = r;
      in_pc     = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = m_halt ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; in_valid = 0; flush = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
